// File: rtl/conv_layer_sequencer.sv
// Frame sequencer for the 16-channel conv featuremap: walks a zero-padded
// (WIDTH+2)^2 raster, pops all source FIFOs in lockstep and counts results.
module conv_layer_sequencer #(
  parameter int WIDTH = 56,
  parameter int NCH   = 16
) (
  input  logic                               clk,
  input  logic                               rst,
  input  logic                               start,
  input  logic [NCH-1:0]                     fifo_empty,
  input  logic                               fm_ready,
  input  logic                               fm_valid_out,
  output logic                               src_rdreq,
  output logic                               fm_valid,
  output logic                               pad_zero,
  output logic                               busy,
  output logic                               done,
  output logic [$clog2(WIDTH*WIDTH+1)-1:0]   out_count
);

  localparam int PW  = WIDTH + 2;
  localparam int RCW = $clog2(PW);
  localparam int CW  = $clog2(WIDTH*WIDTH+1);
  localparam logic [RCW-1:0] LAST    = RCW'(PW - 1);
  localparam logic [CW-1:0]  OUT_MAX = CW'(WIDTH * WIDTH);

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

  state_t         state, state_next;
  logic [RCW-1:0] row, col;
  logic           border, issue, count_en;
  logic [CW-1:0]  count_next;

  // Border pixels are synthesised as zeros, so they never wait on the FIFOs.
  always_comb begin
    border    = (row == '0) || (row == LAST) || (col == '0) || (col == LAST);
    issue     = (state == RUN) && fm_ready && (border || (fifo_empty == '0));
    fm_valid  = issue;
    pad_zero  = issue && border;
    src_rdreq = issue && !border;
  end

  always_comb begin
    count_en   = ((state == RUN) || (state == DRAIN)) && fm_valid_out && (out_count != OUT_MAX);
    count_next = out_count + CW'(count_en);
  end

  // DRAIN looks at the post-increment count so done follows the last result by one cycle.
  always_comb begin
    state_next = state;
    unique case (state)
      IDLE:  if (start) state_next = RUN;
      RUN:   if (issue && (row == LAST) && (col == LAST)) state_next = DRAIN;
      DRAIN: if (count_next == OUT_MAX) state_next = DONE;
      DONE:  state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      row       <= '0;
      col       <= '0;
      out_count <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      state <= state_next;
      busy  <= (state_next == RUN) || (state_next == DRAIN);
      done  <= (state_next == DONE);
      if ((state == IDLE) && start) begin
        row       <= '0;
        col       <= '0;
        out_count <= '0;
      end else begin
        out_count <= count_next;
        if (issue) begin
          if (col == LAST) begin
            col <= '0;
            row <= row + 1'b1;
          end else begin
            col <= col + 1'b1;
          end
        end
      end
    end
  end

endmodule

// File: doc/conv_layer_sequencer.md
Name: conv_layer_sequencer

Overview:
- Sequences one full input frame through a 16-input-channel conv featuremap block (3x3 conv2D per channel, line buffers sized for a padded width of WIDTH+2, bias-add adder tree).
- Pops all 16 source channel FIFOs in lockstep and drives a common valid into the featuremap.
- Generates the 1-pixel zero border in-stream, so the featuremap sees a (WIDTH+2)x(WIDTH+2) frame.
- Counts featuremap results and signals frame completion to the layer controller.

Parameters:
- WIDTH, 56: unpadded frame width and height in pixels. Padded frame PW = WIDTH+2.
- NCH, 16: number of input channels. Fixed at 16 for this layer; the parameter exists for the bench only.

Ports:
- clk  in  1  : system clock, rising edge.
- rst  in  1  : asynchronous active-high reset.
- start  in  1  : one-cycle request to process one frame. Ignored unless the FSM is in IDLE.
- fifo_empty  in  NCH  : bit i is the empty flag of source FIFO i. Source FIFOs are show-ahead.
- fm_ready  in  1  : featuremap line-buffer read request; high means a pixel is accepted this cycle.
- fm_valid_out  in  1  : featuremap valid_out; pulses once per output pixel.
- src_rdreq  out  1  : common pop to all NCH source FIFOs.
- fm_valid  out  1  : common pixel-valid to the featuremap. Each channel's empty input is driven with ~fm_valid.
- pad_zero  out  1  : selects 32'h0000_0000 instead of FIFO data on all channels.
- busy  out  1  : high in RUN and DRAIN.
- done  out  1  : one-cycle pulse at frame completion.
- out_count  out  clog2(WIDTH*WIDTH+1)  : featuremap outputs received in the current frame.

Behaviour:
- Reset (async, rst=1): FSM=IDLE; row, col and out_count = 0; busy=0; done=0. src_rdreq, fm_valid and pad_zero evaluate to 0.
- FSM states: IDLE, RUN, DRAIN, DONE.
  - IDLE -> RUN on start=1. row=0, col=0, out_count=0 are loaded on the transition.
  - RUN -> DRAIN on the cycle an issue occurs at (row,col)=(PW-1,PW-1).
  - DRAIN -> DONE when out_count reaches WIDTH*WIDTH.
  - DONE -> IDLE after 1 cycle.
- Border position: row==0 or row==PW-1 or col==0 or col==PW-1. Every other position is interior.
- Issue condition: state==RUN and fm_ready=1 and (border or all fifo_empty bits == 0).
  - Border issue: fm_valid=1, pad_zero=1, src_rdreq=0.
  - Interior issue: fm_valid=1, pad_zero=0, src_rdreq=1.
  - src_rdreq, fm_valid and pad_zero are combinational from state, row, col, fm_ready and fifo_empty. There is zero latency from the issue condition to the pop.
- Stall: in RUN with no issue (fm_ready=0, or interior with any FIFO empty), all three outputs are 0 and row/col hold.
  - A partially empty FIFO set never causes a pop. All channels advance together or not at all.
- Counter advance on each issue: col increments. When col==PW-1, col wraps to 0 and row increments.
- Issues per frame: exactly PW*PW total, of which WIDTH*WIDTH are pops and 4*WIDTH+4 are pads.
- out_count: increments on fm_valid_out=1 in RUN or DRAIN, saturating at WIDTH*WIDTH.
  - Results may arrive during RUN. They are counted.
  - fm_valid_out in IDLE or DONE is ignored.
- done: registered. High for the single cycle in DONE. busy=0 in DONE.
- start while busy, or in DONE: ignored, with no effect on counters.
- start in the same cycle as done: ignored. A new frame needs start in IDLE.
- Reset mid-frame: returns to IDLE immediately and clears all counters. Source FIFO contents are left untouched.
- No timeout: DRAIN waits indefinitely for outputs.

Test Plan (WIDTH=4, PW=6, NCH=16):
- Full frame, all FIFOs always non-empty, fm_ready=1, start pulse:
  - 36 consecutive fm_valid cycles: first 7 pads, then 4 pops / 2 pads per row; 16 src_rdreq total and 20 pad_zero total.
  - Bench returns 16 fm_valid_out pulses -> done one cycle after the 16th counted output; out_count=16; busy falls.
- Interior stall: fifo_empty[9]=1 for 5 cycles at (row,col)=(2,3):
  - No src_rdreq and no fm_valid for those 5 cycles; row/col hold at (2,3).
  - The pop issues on the cycle fifo_empty[9] clears.
- Border ignores empties: all fifo_empty=1 from start -> first 7 border issues complete (pad_zero=1, src_rdreq=0), then the block stalls at (1,1).
- Backpressure: fm_ready toggles 1,0,1,0 across the frame -> exactly 36 issues, each only on fm_ready=1 cycles; issue ordering identical to the first scenario.
- start while busy plus late outputs: start pulsed in RUN and again in DRAIN -> no restart. 17 fm_valid_out pulses -> out_count saturates at 16; exactly one done pulse.
- Async reset at (row,col)=(3,2): outputs 0 without waiting for a clock edge; state IDLE and out_count=0. A subsequent start runs a clean 36-issue frame.
